eco_match_engine: RTL and testbench

- Parametrised, sequential successor to the combinational ECO target-compare logic.
- Each accepted beat carries NUM_CH candidate words. A one-hot-free binary select picks one word, which is compared against a programmable reference under a bit mask.
- A target flag asserts once CFG-programmed consecutive matches are counted.
- Sits between the channel-select datapath and the patch-target consumer.

---
 rtl/eco_match_engine.sv | 120 ++++++++++++
 tb/tb_eco_match_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eco_match_engine.sv
// Sequential ECO target-compare: selects one of NUM_CH words per accepted beat,
// compares it under a mask against a reference and flags a run of consecutive matches.
module eco_match_engine #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SELW   = 2,
    parameter int CNTW   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [WIDTH-1:0]        cfg_ref,
    input  logic [WIDTH-1:0]        cfg_mask,
    input  logic [CNTW-1:0]         cfg_thresh,
    input  logic                    arm,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SELW-1:0]         in_sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    target,
    output logic [CNTW-1:0]         hit_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNTW-1:0]  thresh_q;

    logic             s1_valid;
    logic             s1_bad;
    logic [WIDTH-1:0] s1_word;

    logic             accept;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_word;
    logic             s2_match;
    logic [CNTW-1:0]  cnt_next;

    assign in_ready = (state == ARMED) && arm;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign sel_ok   = ({1'b0, in_sel} < (SELW+1)'(NUM_CH));

    // NOTE: the default before the loop keeps this purely combinational; without it
    // an out-of-range select would leave sel_word unassigned and infer a latch.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SELW'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign s2_match = !s1_bad && (((s1_word ^ ref_q) & mask_q) == '0);
    assign cnt_next = !s2_match          ? '0 :
                      (hit_cnt == '1)    ? hit_cnt :
                                           hit_cnt + CNTW'(1);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; stage 2 must see the old stage-1 contents while stage 1 reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ref_q    <= '0;
            mask_q   <= '0;
            thresh_q <= CNTW'(1);
            s1_valid <= 1'b0;
            s1_bad   <= 1'b0;
            s1_word  <= '0;
            hit_cnt  <= '0;
            target   <= 1'b0;
        end else begin
            if (cfg_we && state == IDLE) begin
                ref_q    <= cfg_ref;
                mask_q   <= cfg_mask;
                thresh_q <= (cfg_thresh == '0) ? CNTW'(1) : cfg_thresh;
            end
            s1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) state <= ARMED;
                end
                ARMED: begin
                    if (!arm) begin
                        state   <= IDLE;
                        hit_cnt <= '0;
                        target  <= 1'b0;
                    end else begin
                        s1_valid <= accept;
                        s1_word  <= sel_word;
                        s1_bad   <= !sel_ok;
                        if (s1_valid) begin
                            hit_cnt <= cnt_next;
                            if (cnt_next >= thresh_q) begin
                                target <= 1'b1;
                                state  <= HIT;
                            end
                        end
                    end
                end
                HIT: begin
                    // Count is frozen here; anything left in stage 1 is simply dropped.
                    if (!arm) begin
                        state   <= IDLE;
                        hit_cnt <= '0;
                        target  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eco_match_engine.sv
// Scoreboard bench for eco_match_engine: a beat-level reference model queues expected
// hit_cnt/target per accepted beat; a negedge monitor compares two edges after acceptance.
module tb_eco_match_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_ref;
    logic [7:0]  cfg_mask;
    logic [3:0]  cfg_thresh;
    logic        arm;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [31:0] in_data;

    logic        in_ready, target, busy;
    logic [3:0]  hit_cnt;
    logic        in_ready3, target3, busy3;
    logic [3:0]  hit_cnt3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tgt;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: counts matching accepted beats since arming.
    logic [7:0] m_ref, m_mask;
    logic [3:0] m_thresh, m_cnt;
    bit         m_armed, m_hit;
    int         m_lock;

    always #5 clk = ~clk;

    eco_match_engine #(.NUM_CH(4), .WIDTH(8), .SELW(2), .CNTW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ref(cfg_ref), .cfg_mask(cfg_mask),
        .cfg_thresh(cfg_thresh), .arm(arm), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .target(target), .hit_cnt(hit_cnt), .busy(busy)
    );

    eco_match_engine #(.NUM_CH(3), .WIDTH(8), .SELW(2), .CNTW(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ref(cfg_ref), .cfg_mask(cfg_mask),
        .cfg_thresh(cfg_thresh), .arm(arm), .in_valid(in_valid), .in_ready(in_ready3),
        .in_sel(in_sel), .in_data(in_data[23:0]), .target(target3), .hit_cnt(hit_cnt3),
        .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a beat seen accepted mid-cycle has its result visible two negedges later.
    logic [1:0] pend = 2'b00;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 2'b00;
            exp_q.delete();
        end else begin
            if (pend[1]) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_hit_cnt", 32'(hit_cnt), 32'(e.cnt));
                    check("sb_target", 32'(target), 32'(e.tgt));
                end
            end
            pend = {pend[0], in_valid & in_ready};
        end
    end

    task automatic model_beat(input logic [1:0] sel, input logic [31:0] data);
        logic [7:0] w;
        if (m_hit) begin
            exp_q.push_back('{cnt: m_cnt, tgt: 1'b1});
        end else begin
            w = data[int'(sel)*8 +: 8];
            if (((w ^ m_ref) & m_mask) == 8'h00) m_cnt = (m_cnt == 4'hF) ? m_cnt : m_cnt + 4'd1;
            else                                 m_cnt = 4'd0;
            if (m_cnt >= m_thresh) begin
                m_hit  = 1'b1;
                m_lock = 1;
            end
            exp_q.push_back('{cnt: m_cnt, tgt: m_hit});
        end
    endtask

    task automatic cycle(input bit offer, input logic [1:0] sel, input logic [31:0] data);
        bit exp_ready;
        exp_ready = m_armed && (!m_hit || m_lock > 0);
        if (m_hit && m_lock > 0) m_lock--;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        in_valid = offer;
        in_sel   = sel;
        in_data  = data;
        if (offer && exp_ready) model_beat(sel, data);
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] r, input logic [7:0] m, input logic [3:0] t);
        cfg_we = 1'b1; cfg_ref = r; cfg_mask = m; cfg_thresh = t;
        @(posedge clk) #1;
        cfg_we   = 1'b0;
        m_ref    = r;
        m_mask   = m;
        m_thresh = (t == 4'd0) ? 4'd1 : t;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk) #1;
        m_armed = 1'b1; m_cnt = 4'd0; m_hit = 1'b0; m_lock = 0;
    endtask

    task automatic do_disarm();
        arm = 1'b0; in_valid = 1'b0;
        @(posedge clk) #1;
        m_armed = 1'b0; m_cnt = 4'd0; m_hit = 1'b0; m_lock = 0;
        check("disarm_target", 32'(target), 32'd0);
        check("disarm_hit_cnt", 32'(hit_cnt), 32'd0);
        check("disarm_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  s;
        logic [31:0] d;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ref = '0; cfg_mask = '0; cfg_thresh = '0;
        arm = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
        m_ref = '0; m_mask = '0; m_thresh = 4'd1; m_cnt = '0; m_armed = 0; m_hit = 0; m_lock = 0;

        // Reset then idle.
        repeat (3) begin
            @(posedge clk) #1;
            check("rst_target", 32'(target), 32'd0);
            check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 2'd0, 32'd0);

        // Basic hit, then config write while in HIT must be ignored.
        set_cfg(8'hA5, 8'hFF, 4'd3);
        do_arm();
        repeat (3) cycle(1'b1, 2'd2, 32'h12A5_3456);
        repeat (3) cycle(1'b0, 2'd0, 32'd0);
        check("hit_target", 32'(target), 32'd1);
        check("hit_busy", 32'(busy), 32'd1);
        cfg_we = 1'b1; cfg_ref = 8'h00; cfg_mask = 8'h00; cfg_thresh = 4'd1;
        cycle(1'b0, 2'd0, 32'd0);
        cfg_we = 1'b0;
        do_disarm();
        do_arm();
        cycle(1'b1, 2'd0, 32'h0000_00A5);
        cycle(1'b1, 2'd0, 32'h0000_0000);
        repeat (3) cycle(1'b0, 2'd0, 32'd0);
        do_disarm();

        // Mismatch restarts the run.
        set_cfg(8'hA5, 8'hFF, 4'd3);
        do_arm();
        cycle(1'b1, 2'd1, 32'h0000_A500);
        cycle(1'b1, 2'd1, 32'h0000_A500);
        cycle(1'b1, 2'd1, 32'h0000_A400);
        cycle(1'b1, 2'd1, 32'h0000_A500);
        repeat (3) cycle(1'b0, 2'd0, 32'd0);
        check("restart_target", 32'(target), 32'd0);
        do_disarm();

        // Mask and invalid select (sel=3 is out of range only on the 3-channel instance).
        set_cfg(8'hA0, 8'hF0, 4'd15);
        do_arm();
        check("dut3_in_ready", 32'(in_ready3), 32'd1);
        cycle(1'b1, 2'd1, 32'h0000_AF00);
        cycle(1'b1, 2'd3, 32'hA000_0000);
        check("dut3_mask_match", 32'(hit_cnt3), 32'd1);
        cycle(1'b0, 2'd0, 32'd0);
        check("dut3_bad_sel", 32'(hit_cnt3), 32'd0);
        check("dut3_target", 32'(target3), 32'd0);
        check("dut3_busy", 32'(busy3), 32'd1);
        repeat (2) cycle(1'b0, 2'd0, 32'd0);
        do_disarm();

        // Zero threshold acts as one, zero mask matches anything.
        set_cfg(8'h3C, 8'h00, 4'd0);
        do_arm();
        cycle(1'b1, 2'd3, 32'h5A5A_5A5A);
        repeat (3) cycle(1'b0, 2'd0, 32'd0);
        do_disarm();

        // Arm drop on the same edge the threshold would be reached: IDLE wins.
        set_cfg(8'hA5, 8'hFF, 4'd1);
        do_arm();
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h0000_00A5;
        exp_q.push_back('{cnt: 4'd0, tgt: 1'b0});
        @(posedge clk) #1;
        in_valid = 1'b0; arm = 1'b0;
        m_armed = 1'b0; m_cnt = 4'd0; m_hit = 1'b0;
        @(posedge clk) #1;
        check("race_target", 32'(target), 32'd0);
        check("race_busy", 32'(busy), 32'd0);
        repeat (2) cycle(1'b0, 2'd0, 32'd0);

        // Async reset mid-run with hit_cnt=2.
        set_cfg(8'hA5, 8'hFF, 4'd5);
        do_arm();
        repeat (2) cycle(1'b1, 2'd0, 32'h0000_00A5);
        repeat (2) cycle(1'b0, 2'd0, 32'd0);
        check("pre_reset_hit_cnt", 32'(hit_cnt), 32'd2);
        #3 rst_n = 1'b0; arm = 1'b0;
        #1;
        check("async_hit_cnt", 32'(hit_cnt), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        m_ref = '0; m_mask = '0; m_thresh = 4'd1; m_cnt = '0; m_armed = 0; m_hit = 0; m_lock = 0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        do_arm();
        cycle(1'b1, 2'd2, 32'h1234_5678);
        repeat (3) cycle(1'b0, 2'd0, 32'd0);
        do_disarm();

        // Randomized episodes against the model.
        for (int ep = 0; ep < 20; ep++) begin
            set_cfg(8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)));
            do_arm();
            for (int c = 0; c < 30; c++) begin
                s = 2'($urandom);
                d = $urandom;
                if ($urandom_range(0, 9) < 7) d[int'(s)*8 +: 8] = m_ref ^ (8'($urandom) & ~m_mask);
                cycle($urandom_range(0, 3) != 0, s, d);
            end
            repeat (3) cycle(1'b0, 2'd0, 32'd0);
            do_disarm();
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
